fetch_unit: RTL and testbench

//  Fetch responder for the core scheduler. When the active warp is in FETCH, it returns the instruction at current_pc and reports FETCHED on fetcher_state.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch responder: serves the active warp's PC from a small
// direct-mapped cache, or from program memory over a valid/ready read port.
module fetch_unit #(
  parameter int ADDR_BITS    = 8,
  parameter int INSTR_BITS   = 16,
  parameter int CACHE_LINES  = 16,
  parameter int CACHE_ENABLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            core_state,
  input  logic [ADDR_BITS-1:0]  current_pc,
  input  logic                  flush,
  output logic                  mem_read_valid,
  output logic [ADDR_BITS-1:0]  mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [INSTR_BITS-1:0] mem_read_data,
  output logic [2:0]            fetcher_state,
  output logic [INSTR_BITS-1:0] instruction
);

  localparam int          IDX_BITS = $clog2(CACHE_LINES);
  localparam int          TAG_BITS = ADDR_BITS - IDX_BITS;
  localparam logic [3:0]  CORE_FETCH = 4'b0001;
  localparam logic        USE_CACHE  = (CACHE_ENABLE != 0);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_FETCHING = 3'b001,
    ST_FETCHED  = 3'b010
  } state_t;

  state_t                state_q;
  logic                  mem_valid_q;
  logic [ADDR_BITS-1:0]  mem_addr_q;
  logic [INSTR_BITS-1:0] instr_q;
  logic [ADDR_BITS-1:0]  fetch_pc_q;

  logic [CACHE_LINES-1:0] line_valid_q, line_valid_d;
  logic [TAG_BITS-1:0]    line_tag_q  [CACHE_LINES];
  logic [INSTR_BITS-1:0]  line_data_q [CACHE_LINES];

  logic [IDX_BITS-1:0]   lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  lk_hit;
  logic [INSTR_BITS-1:0] lk_data;
  logic [IDX_BITS-1:0]   fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  fill_en;

  // Lookup reads the pre-edge array, so a same-cycle flush cannot hide a hit.
  assign lk_idx  = current_pc[IDX_BITS-1:0];
  assign lk_tag  = current_pc[ADDR_BITS-1:IDX_BITS];
  assign lk_data = line_data_q[lk_idx];
  assign lk_hit  = USE_CACHE && line_valid_q[lk_idx] && (line_tag_q[lk_idx] == lk_tag);

  assign fill_idx = fetch_pc_q[IDX_BITS-1:0];
  assign fill_tag = fetch_pc_q[ADDR_BITS-1:IDX_BITS];
  assign fill_en  = USE_CACHE && !reset && (state_q == ST_FETCHING) && mem_read_ready;

  // Scheduler-facing FSM; all outputs come straight from registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      instr_q     <= '0;
      fetch_pc_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (core_state == CORE_FETCH) begin
            fetch_pc_q <= current_pc;
            if (lk_hit) begin
              instr_q <= lk_data;
              state_q <= ST_FETCHED;
            end else begin
              mem_valid_q <= 1'b1;
              mem_addr_q  <= current_pc;
              state_q     <= ST_FETCHING;
            end
          end
        end
        ST_FETCHING: begin
          // Completes even if the scheduler left FETCH meanwhile.
          if (mem_read_ready) begin
            instr_q     <= mem_read_data;
            mem_valid_q <= 1'b0;
            state_q     <= ST_FETCHED;
          end
        end
        ST_FETCHED: begin
          if ((core_state != CORE_FETCH) || (current_pc != fetch_pc_q)) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          mem_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Flush takes priority over a coincident fill.
  always_comb begin
    line_valid_d = line_valid_q;
    if (flush) begin
      line_valid_d = '0;
    end else if (fill_en) begin
      line_valid_d[fill_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid_q <= '0;
    end else begin
      line_valid_q <= line_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_tag_q[fill_idx]  <= fill_tag;
      line_data_q[fill_idx] <= mem_read_data;
    end
  end

  assign mem_read_valid   = mem_valid_q;
  assign mem_read_address = mem_addr_q;
  assign fetcher_state    = state_q;
  assign instruction      = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// and randomized fetches checked against an abstract cache model.
module tb_fetch_unit;

  localparam int AB = 8;
  localparam int IB = 16;
  localparam int CL = 16;
  localparam logic [3:0] FETCH  = 4'b0001;
  localparam logic [3:0] DECODE = 4'b0010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [3:0]    core_state;
  logic [AB-1:0] current_pc;
  logic          flush;
  logic          mem_read_valid;
  logic [AB-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [IB-1:0] mem_read_data;
  logic [2:0]    fetcher_state;
  logic [IB-1:0] instruction;

  logic [3:0]    nc_core_state;
  logic [AB-1:0] nc_pc;
  logic          nc_valid;
  logic [AB-1:0] nc_addr;
  logic          nc_ready;
  logic [IB-1:0] nc_data;
  logic [2:0]    nc_state;
  logic [IB-1:0] nc_instr;

  fetch_unit #(.ADDR_BITS(AB), .INSTR_BITS(IB), .CACHE_LINES(CL), .CACHE_ENABLE(1)) dut (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
    .flush(flush), .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state), .instruction(instruction));

  fetch_unit #(.ADDR_BITS(AB), .INSTR_BITS(IB), .CACHE_LINES(CL), .CACHE_ENABLE(0)) dut_nc (
    .clk(clk), .reset(reset), .core_state(nc_core_state), .current_pc(nc_pc),
    .flush(1'b0), .mem_read_valid(nc_valid), .mem_read_address(nc_addr),
    .mem_read_ready(nc_ready), .mem_read_data(nc_data),
    .fetcher_state(nc_state), .instruction(nc_instr));

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [IB-1:0] exp_q[$];
  logic [IB-1:0] mem_words [256];
  bit            m_valid [CL];
  logic [AB-1:0] m_pc    [CL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_hit(input logic [AB-1:0] pc);
    return m_valid[pc % CL] && (m_pc[pc % CL] == pc);
  endfunction

  task automatic model_flush();
    for (int i = 0; i < CL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [AB-1:0] pc, input bit flushed);
    if (flushed) model_flush();
    else begin
      m_valid[pc % CL] = 1'b1;
      m_pc[pc % CL]    = pc;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full FETCH transaction from IDLE, acting as the memory responder.
  // wait_n = number of cycles mem_read_valid is high before data returns.
  task automatic do_fetch(input logic [AB-1:0] pc, input int wait_n, input bit flush_at_ready,
                          input bit exp_hit, input logic [IB-1:0] exp_data);
    int cycles = 0;
    int vcnt = 0;
    bit done = 0;
    logic [IB-1:0] got;
    exp_q.push_back(exp_data);
    core_state = FETCH;
    current_pc = pc;
    while (!done) begin
      tick();
      cycles++;
      mem_read_ready = 1'b0;
      flush          = 1'b0;
      mem_read_data  = IB'($urandom);
      check("valid_outside_fetching", 32'(mem_read_valid && (fetcher_state != 3'b001)), 32'd0);
      if (fetcher_state == 3'b010) done = 1;
      else if (mem_read_valid) begin
        vcnt++;
        check("req_addr", 32'(mem_read_address), 32'(pc));
        if (vcnt == wait_n) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem_words[pc];
          flush          = flush_at_ready;
        end
      end
      if (cycles > 60) begin
        check("fetch_timeout", 32'd1, 32'd0);
        done = 1;
      end
    end
    check("latency", 32'(cycles), exp_hit ? 32'd1 : 32'(wait_n + 1));
    check("mem_reads", 32'(vcnt), exp_hit ? 32'd0 : 32'(wait_n));
    got = instruction;
    check("instruction", 32'(got), 32'(exp_q.pop_front()));
    if (!exp_hit) model_fill(pc, flush_at_ready);
    core_state = DECODE;
    tick();
    check("exit_to_idle", 32'(fetcher_state), 32'd0);
    check("instr_held_after_exit", 32'(instruction), 32'(got));
  endtask

  task automatic nc_fetch(input logic [AB-1:0] pc);
    int cycles = 0;
    int vcnt = 0;
    bit done = 0;
    nc_core_state = FETCH;
    nc_pc = pc;
    while (!done) begin
      tick();
      cycles++;
      nc_ready = 1'b0;
      nc_data  = IB'($urandom);
      if (nc_state == 3'b010) done = 1;
      else if (nc_valid) begin
        vcnt++;
        nc_ready = 1'b1;
        nc_data  = mem_words[pc];
      end
      if (cycles > 60) begin
        check("nc_timeout", 32'd1, 32'd0);
        done = 1;
      end
    end
    check("nc_mem_reads", 32'(vcnt), 32'd1);
    check("nc_instruction", 32'(nc_instr), 32'(mem_words[pc]));
    nc_core_state = DECODE;
    tick();
  endtask

  typedef struct {
    logic [AB-1:0] pc;
    int            wait_n;
    bit            flush_at_ready;
    bit            exp_hit;
    logic [IB-1:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  // ---------------- test sequence ----------------
  initial begin
    logic [AB-1:0] pc;
    for (int i = 0; i < 256; i++) mem_words[i] = IB'($urandom);
    mem_words[8'h10] = 16'hA5C3;
    mem_words[8'h20] = 16'h1234;
    mem_words[8'h30] = 16'hBEEF;
    mem_words[8'hFF] = 16'h7E57;
    model_flush();

    vecs[0] = '{8'h10, 3, 1'b0, 1'b0, 16'hA5C3};  // cold miss
    vecs[1] = '{8'h10, 1, 1'b0, 1'b1, 16'hA5C3};  // hit
    vecs[2] = '{8'h20, 2, 1'b0, 1'b0, 16'h1234};  // alias evicts 0x10
    vecs[3] = '{8'h10, 1, 1'b0, 1'b0, 16'hA5C3};  // evicted -> miss
    vecs[4] = '{8'h30, 2, 1'b1, 1'b0, 16'hBEEF};  // flush coincident with fill
    vecs[5] = '{8'h30, 1, 1'b0, 1'b0, 16'hBEEF};  // fill lost -> miss
    vecs[6] = '{8'h30, 1, 1'b0, 1'b1, 16'hBEEF};
    vecs[7] = '{8'hFF, 1, 1'b0, 1'b0, 16'h7E57};  // top address
    vecs[8] = '{8'hFF, 1, 1'b0, 1'b1, 16'h7E57};

    reset = 1'b1; core_state = DECODE; current_pc = '0; flush = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = '0;
    nc_core_state = DECODE; nc_pc = '0; nc_ready = 1'b0; nc_data = '0;
    tick(); tick();
    check("rst_state", 32'(fetcher_state), 32'd0);
    check("rst_valid", 32'(mem_read_valid), 32'd0);
    check("rst_addr", 32'(mem_read_address), 32'd0);
    check("rst_instr", 32'(instruction), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++)
      do_fetch(vecs[i].pc, vecs[i].wait_n, vecs[i].flush_at_ready, vecs[i].exp_hit, vecs[i].exp_data);

    // Flush on the same edge as an IDLE hit: hit still served from old contents.
    core_state = FETCH; current_pc = 8'h30; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_hit_state", 32'(fetcher_state), 32'd2);
    check("flush_hit_instr", 32'(instruction), 32'hBEEF);
    check("flush_hit_no_req", 32'(mem_read_valid), 32'd0);
    core_state = DECODE;
    tick();
    model_flush();
    do_fetch(8'h30, 2, 1'b0, 1'b0, 16'hBEEF);

    // Stale result: PC changes while FETCHED in FETCH.
    core_state = FETCH; current_pc = 8'h30;
    tick();
    check("stale_fetched", 32'(fetcher_state), 32'd2);
    current_pc = 8'h10;
    tick();
    check("stale_exit", 32'(fetcher_state), 32'd0);
    check("stale_instr_kept", 32'(instruction), 32'hBEEF);
    core_state = DECODE;
    tick();

    // Reset in the middle of a memory request.
    do_fetch(8'h40, 1, 1'b0, model_hit(8'h40), mem_words[8'h40]);
    core_state = FETCH; current_pc = 8'h41;
    tick();
    check("pre_reset_valid", 32'(mem_read_valid), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_reset_valid", 32'(mem_read_valid), 32'd0);
    check("mid_reset_state", 32'(fetcher_state), 32'd0);
    reset = 1'b0; core_state = DECODE;
    tick();
    model_flush();
    do_fetch(8'h41, 2, 1'b0, 1'b0, mem_words[8'h41]);
    do_fetch(8'h40, 1, 1'b0, 1'b0, mem_words[8'h40]);

    // Scheduler leaves FETCH while the request is outstanding.
    core_state = FETCH; current_pc = 8'h50;
    tick();
    check("leave_valid", 32'(mem_read_valid), 32'd1);
    core_state = DECODE; mem_read_ready = 1'b1; mem_read_data = mem_words[8'h50];
    tick();
    mem_read_ready = 1'b0;
    check("leave_fetched", 32'(fetcher_state), 32'd2);
    check("leave_instr", 32'(instruction), 32'(mem_words[8'h50]));
    tick();
    check("leave_idle", 32'(fetcher_state), 32'd0);
    model_fill(8'h50, 1'b0);
    do_fetch(8'h50, 1, 1'b0, 1'b1, mem_words[8'h50]);

    // Cache disabled: every access goes to memory.
    nc_fetch(8'h05);
    nc_fetch(8'h05);

    // Randomized fetches against the model; small PC pool forces hits and aliases.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) pc = 8'hFF;
      else pc = AB'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 1) ? 15 : $urandom_range(0, 2)));
      if ($urandom_range(0, 7) == 0) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_flush();
      end
      do_fetch(pc, $urandom_range(1, 4), ($urandom_range(0, 7) == 0), model_hit(pc), mem_words[pc]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
